// File: rtl/aoi222_rr_arb3.sv
// Three-requester round-robin arbiter with bounded hold time and a one-cycle
// break-before-make gap, driving the select terms of a shared AOI222 path.
module aoi222_rr_arb3 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       CK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic       RLS,
  input  logic [2:0] D,
  output logic [2:0] GNT,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       ZN
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_r, state_n;
  logic [2:0] gnt_r, gnt_n;
  logic [1:0] owner_r, owner_n;
  logic       busy_r, busy_n;
  logic       zn_r;
  logic [7:0] hcnt_r, hcnt_n;
  logic [1:0] ptr_r, ptr_n;
  logic [1:0] win_s;
  logic       release_s;

  // First asserted request after the last owner; the last owner comes last.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    case (ptr)
      2'd0: begin
        if (req[1])      pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick = 2'd0;
      end
      2'd1: begin
        if (req[2])      pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick = 2'd1;
      end
      default: begin
        if (req[0])      pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick = 2'd2;
      end
    endcase
    return pick;
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

  // Owner gives up the bus on release, on dropping its request, or at the hold limit.
  assign win_s     = rr_pick(REQ, ptr_r);
  assign release_s = RLS || ((REQ & gnt_r) == 3'b000) || (hcnt_r == HOLD_LAST);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_n = state_r;
    gnt_n   = gnt_r;
    owner_n = owner_r;
    busy_n  = busy_r;
    hcnt_n  = hcnt_r;
    ptr_n   = ptr_r;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (REQ != 3'b000) begin
          state_n = ST_GRANT;
          gnt_n   = idx_to_onehot(win_s);
          owner_n = win_s;
          busy_n  = 1'b1;
          hcnt_n  = 8'd0;
          ptr_n   = win_s;
        end else begin
          state_n = ST_IDLE;
          gnt_n   = 3'b000;
          busy_n  = 1'b0;
          hcnt_n  = 8'd0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_n = ST_GAP;
          gnt_n   = 3'b000;
          busy_n  = 1'b0;
          hcnt_n  = 8'd0;
        end else begin
          hcnt_n  = hcnt_r + 8'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 3'b000;
        busy_n  = 1'b0;
        hcnt_n  = 8'd0;
      end
    endcase
  end

  // State and registered outputs; reset leaves requester 0 with top priority.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      gnt_r   <= 3'b000;
      owner_r <= 2'd0;
      busy_r  <= 1'b0;
      hcnt_r  <= 8'd0;
      ptr_r   <= 2'd2;
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      owner_r <= owner_n;
      busy_r  <= busy_n;
      hcnt_r  <= hcnt_n;
      ptr_r   <= ptr_n;
    end
  end

  // Shared AOI222 output, evaluated with the grant in force before the edge.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      zn_r <= 1'b1;
    end else begin
      zn_r <= ~|(D & gnt_r);
    end
  end

  assign GNT   = gnt_r;
  assign OWNER = owner_r;
  assign BUSY  = busy_r;
  assign ZN    = zn_r;

endmodule

// File: tb/tb_aoi222_rr_arb3.sv
// Directed self-checking bench for aoi222_rr_arb3 (default hold and hold of one),
// with a continuous grant-protocol monitor.
module tb_aoi222_rr_arb3;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] REQ = 3'b000;
  logic       RLS = 1'b0;
  logic [2:0] D = 3'b000;
  logic [2:0] GNT, GNT1;
  logic [1:0] OWNER, OWNER1;
  logic       BUSY, BUSY1;
  logic       ZN, ZN1;

  int checks = 0;
  int errors = 0;
  int mon_viol = 0;

  aoi222_rr_arb3 #(.MAX_HOLD(8)) u_dut (
    .CK(CK), .RST(RST), .REQ(REQ), .RLS(RLS), .D(D),
    .GNT(GNT), .OWNER(OWNER), .BUSY(BUSY), .ZN(ZN)
  );

  aoi222_rr_arb3 #(.MAX_HOLD(1)) u_dut1 (
    .CK(CK), .RST(RST), .REQ(REQ), .RLS(RLS), .D(D),
    .GNT(GNT1), .OWNER(OWNER1), .BUSY(BUSY1), .ZN(ZN1)
  );

  always #5 CK = ~CK;

  // Continuous protocol monitor: one-hot-or-zero, no make-before-break, BUSY/OWNER consistency.
  logic [2:0] prev_gnt = 3'b000;
  logic [2:0] prev_gnt1 = 3'b000;
  always @(negedge CK) begin
    if (RST) begin
      prev_gnt  <= 3'b000;
      prev_gnt1 <= 3'b000;
    end else begin
      if (!(GNT inside {3'b000, 3'b001, 3'b010, 3'b100}) ||
          !(GNT1 inside {3'b000, 3'b001, 3'b010, 3'b100})) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL monitor_onehot: got GNT=%b GNT1=%b, need one-hot or zero", GNT, GNT1);
      end
      if ((prev_gnt != 3'b000 && GNT != 3'b000 && GNT != prev_gnt) ||
          (prev_gnt1 != 3'b000 && GNT1 != 3'b000 && GNT1 != prev_gnt1)) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL monitor_gap: got %b->%b / %b->%b, need a zero gap between owners",
                 prev_gnt, GNT, prev_gnt1, GNT1);
      end
      if (BUSY !== (|GNT) || (BUSY && (3'b001 << OWNER) !== GNT)) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL monitor_busy_owner: got BUSY=%b OWNER=%0d GNT=%b, need BUSY=|GNT and GNT[OWNER]",
                 BUSY, OWNER, GNT);
      end
      prev_gnt  <= GNT;
      prev_gnt1 <= GNT1;
    end
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    REQ = 3'b000;
    RLS = 1'b0;
    D   = 3'b000;
    repeat (2) @(posedge CK);
    #3;
    RST = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    checks++;
    if (GNT !== 3'b000 || BUSY !== 1'b0 || OWNER !== 2'd0 || ZN !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got GNT=%b BUSY=%b OWNER=%0d ZN=%b, need 000 0 0 1",
               GNT, BUSY, OWNER, ZN);
    end
    RST = 1'b0;
    step();
    checks++;
    if (GNT !== 3'b000 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got GNT=%b BUSY=%b, need 000 0", GNT, BUSY);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] seq [3];
    seq[0] = 3'b001;
    seq[1] = 3'b010;
    seq[2] = 3'b100;
    apply_reset();
    REQ = 3'b111;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        step();
        checks++;
        if (GNT !== seq[r] || OWNER !== 2'(r)) begin
          errors++;
          $display("FAIL rotation_hold r=%0d i=%0d: got GNT=%b OWNER=%0d, need %b %0d",
                   r, i, GNT, OWNER, seq[r], r);
        end
      end
      step();
      checks++;
      if (GNT !== 3'b000 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL rotation_gap r=%0d: got GNT=%b BUSY=%b, need 000 0", r, GNT, BUSY);
      end
    end
    step();
    checks++;
    if (GNT !== 3'b001) begin
      errors++;
      $display("FAIL rotation_wrap: got GNT=%b, need 001", GNT);
    end
    checks++;
    if (ZN !== 1'b1) begin
      errors++;
      $display("FAIL rotation_zn_d0: got ZN=%b, need 1", ZN);
    end
    REQ = 3'b000;
    step();
    step();
  endtask

  task automatic test_release();
    apply_reset();
    REQ = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (GNT !== 3'b010 || OWNER !== 2'd1) begin
        errors++;
        $display("FAIL release_hold c=%0d: got GNT=%b OWNER=%0d, need 010 1", c, GNT, OWNER);
      end
    end
    RLS = 1'b1;
    step();
    checks++;
    if (GNT !== 3'b000) begin
      errors++;
      $display("FAIL release_gap: got GNT=%b, need 000", GNT);
    end
    RLS = 1'b0;
    REQ = 3'b000;
    step();
    checks++;
    if (GNT !== 3'b000 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: got GNT=%b BUSY=%b, need 000 0", GNT, BUSY);
    end
  endtask

  task automatic test_release_priority();
    apply_reset();
    REQ = 3'b001;
    step();
    checks++;
    if (GNT !== 3'b001) begin
      errors++;
      $display("FAIL prio_owner0: got GNT=%b, need 001", GNT);
    end
    REQ = 3'b101;
    RLS = 1'b1;
    step();
    checks++;
    if (GNT !== 3'b000) begin
      errors++;
      $display("FAIL prio_release_first: got GNT=%b, need 000", GNT);
    end
    RLS = 1'b0;
    step();
    checks++;
    if (GNT !== 3'b100 || OWNER !== 2'd2) begin
      errors++;
      $display("FAIL prio_req2_wins: got GNT=%b OWNER=%0d, need 100 2", GNT, OWNER);
    end
    REQ = 3'b001;
    step();
    checks++;
    if (GNT !== 3'b000) begin
      errors++;
      $display("FAIL prio_drop_gap: got GNT=%b, need 000", GNT);
    end
    step();
    checks++;
    if (GNT !== 3'b001) begin
      errors++;
      $display("FAIL prio_req0_after: got GNT=%b, need 001", GNT);
    end
    REQ = 3'b000;
    step();
    step();
    // RLS while idle must not block a fresh grant.
    REQ = 3'b010;
    RLS = 1'b1;
    step();
    checks++;
    if (GNT !== 3'b010) begin
      errors++;
      $display("FAIL rls_ignored_idle: got GNT=%b, need 010", GNT);
    end
    RLS = 1'b0;
    REQ = 3'b000;
    step();
    step();
  endtask

  task automatic test_zn();
    apply_reset();
    REQ = 3'b010;
    step();
    D = 3'b010;
    step();
    checks++;
    if (ZN !== 1'b0) begin
      errors++;
      $display("FAIL zn_d010: got ZN=%b, need 0", ZN);
    end
    D = 3'b101;
    step();
    checks++;
    if (ZN !== 1'b1) begin
      errors++;
      $display("FAIL zn_d101: got ZN=%b, need 1", ZN);
    end
    D = 3'b111;
    RLS = 1'b1;
    REQ = 3'b000;
    step();
    checks++;
    if (ZN !== 1'b0 || GNT !== 3'b000) begin
      errors++;
      $display("FAIL zn_lag: got ZN=%b GNT=%b, need 0 000", ZN, GNT);
    end
    RLS = 1'b0;
    step();
    checks++;
    if (ZN !== 1'b1) begin
      errors++;
      $display("FAIL zn_gap: got ZN=%b, need 1", ZN);
    end
    D = 3'b000;
  endtask

  task automatic test_max_hold_one();
    logic [2:0] exp1 [7];
    exp1[0] = 3'b001; exp1[1] = 3'b000; exp1[2] = 3'b010; exp1[3] = 3'b000;
    exp1[4] = 3'b100; exp1[5] = 3'b000; exp1[6] = 3'b001;
    apply_reset();
    REQ = 3'b111;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (GNT1 !== exp1[i]) begin
        errors++;
        $display("FAIL hold1_seq i=%0d: got GNT1=%b, need %b", i, GNT1, exp1[i]);
      end
    end
    REQ = 3'b000;
    step();
    step();
  endtask

  task automatic test_async_reset();
    apply_reset();
    REQ = 3'b100;
    step();
    checks++;
    if (GNT !== 3'b100) begin
      errors++;
      $display("FAIL areset_pre: got GNT=%b, need 100", GNT);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (GNT !== 3'b000 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: got GNT=%b BUSY=%b, need 000 0", GNT, BUSY);
    end
    @(posedge CK);
    #3;
    RST = 1'b0;
    REQ = 3'b111;
    step();
    checks++;
    if (GNT !== 3'b001) begin
      errors++;
      $display("FAIL areset_after: got GNT=%b, need 001", GNT);
    end
    REQ = 3'b000;
    step();
    step();
  endtask

  task automatic test_monitor();
    checks++;
    if (mon_viol !== 0) begin
      errors++;
      $display("FAIL protocol_monitor: got %0d violations, need 0", mon_viol);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_release();
    test_release_priority();
    test_zn();
    test_max_hold_one();
    test_async_reset();
    test_monitor();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
